// File: rtl/cache_refill_unit_pkg.sv
// Shared types and line-geometry defaults for the cache refill engine.
// Defaults match the 8-beat cache burst used by both I- and D-cache.
package cache_refill_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } refill_state_t;

  localparam int unsigned DEF_LINE_WORDS = 8;
  localparam int unsigned DEF_OFFSET_W   = 5;

  function automatic int unsigned line_bits(input int unsigned words);
    return words * 32;
  endfunction

endpackage

// File: rtl/cache_refill_unit_if.sv
// Per-cache port of the shared AXI read-port merger.
// master = refill engine, slave = merger.
interface cache_refill_unit_if;
  logic        ren;
  logic        cache_ena;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;

  modport master (
    output ren, cache_ena, araddr, arvalid,
    input  arready, rdata, rlast, rvalid
  );

  modport slave (
    input  ren, cache_ena, araddr, arvalid,
    output arready, rdata, rlast, rvalid
  );
endinterface

// File: rtl/cache_refill_unit_refill_line_buffer.sv
// Line buffer for refill beats: word-indexed writes, wrapping beat counter and
// beat-count mismatch flag evaluated on the last beat.
module refill_line_buffer
  import cache_refill_unit_pkg::*;
#(
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             cached,
  input  logic                             beat_vld,
  input  logic                             beat_last,
  input  logic [31:0]                      beat_data,
  output logic [line_bits(LINE_WORDS)-1:0] line,
  output logic                             err
);
  localparam int unsigned CNT_W = $clog2(LINE_WORDS);

  logic [CNT_W-1:0]            cnt;
  logic                        wrapped;
  logic                        count_ok;
  logic [LINE_WORDS-1:0][31:0] words;

  // Beat count including this last beat matches only if the counter has not
  // wrapped and sits on the final index of the expected burst.
  assign count_ok = !wrapped && (cached ? (cnt == {CNT_W{1'b1}}) : (cnt == '0));
  assign line     = words;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      wrapped <= 1'b0;
      err     <= 1'b0;
      words   <= '0;
    end else if (clear) begin
      cnt     <= '0;
      wrapped <= 1'b0;
    end else if (beat_vld) begin
      if (!wrapped) begin
        words[cnt] <= beat_data;
      end
      cnt <= cnt + 1'b1;
      if (cnt == {CNT_W{1'b1}}) begin
        wrapped <= 1'b1;
      end
      if (beat_last) begin
        err <= !count_ok;
      end
    end
  end

endmodule

// File: rtl/cache_refill_unit.sv
// Per-cache miss engine: issues one AR (line burst or single uncached word),
// collects R beats into a line buffer and pulses done_o with the full line.
module cache_refill_unit
  import cache_refill_unit_pkg::*;
#(
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned OFFSET_W   = DEF_OFFSET_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             miss_req_i,
  input  logic [31:0]                      miss_addr_i,
  input  logic                             cached_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o,
  output logic [line_bits(LINE_WORDS)-1:0] line_o,
  cache_refill_unit_if.master              axi
);

  refill_state_t state, state_nxt;
  logic [31:0]   araddr_q;
  logic          cache_ena_q;
  logic          buf_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (miss_req_i)                 state_nxt = ST_AR;
      ST_AR:   if (axi.arready)                state_nxt = ST_R;
      ST_R:    if (axi.rvalid && axi.rlast)    state_nxt = ST_DONE;
      ST_DONE:                                 state_nxt = ST_IDLE;
      default:                                 state_nxt = ST_IDLE;
    endcase
  end

  // Request is captured once in IDLE and held through AR so the address
  // cannot change before the handshake completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      araddr_q    <= '0;
      cache_ena_q <= 1'b0;
    end else if (state == ST_IDLE && miss_req_i) begin
      araddr_q    <= cached_i ? {miss_addr_i[31:OFFSET_W], {OFFSET_W{1'b0}}}
                              : miss_addr_i;
      cache_ena_q <= cached_i;
    end
  end

  refill_line_buffer #(
    .LINE_WORDS (LINE_WORDS)
  ) u_line_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (state == ST_IDLE),
    .cached    (cache_ena_q),
    .beat_vld  ((state == ST_R) && axi.rvalid),
    .beat_last (axi.rlast),
    .beat_data (axi.rdata),
    .line      (line_o),
    .err       (buf_err)
  );

  assign busy_o        = (state != ST_IDLE);
  assign done_o        = (state == ST_DONE);
  assign err_o         = (state == ST_DONE) && buf_err;
  assign axi.arvalid   = (state == ST_AR);
  assign axi.ren       = (state == ST_AR) || (state == ST_R);
  assign axi.araddr    = araddr_q;
  assign axi.cache_ena = cache_ena_q;

endmodule

// File: doc/cache_refill_unit.md
Name: cache_refill_unit

Overview:
- Per-cache miss engine that sits directly upstream of the shared AXI read-port merger; one instance each for the I-cache and the D-cache.
- Takes a single miss request from a cache and drives the merger's per-cache port: ren, araddr, arvalid and cache-enable.
- Collects the returned R beats into a line buffer and hands the complete line back to the cache with a one-cycle done pulse.
- Also serves uncached single-word reads: single beat, exact address.

Parameters:
LINE_WORDS, 8, words per cache line (power of 2, 2..16); cached burst = LINE_WORDS beats, arlen = LINE_WORDS-1
OFFSET_W, 5, byte-offset bits of a line = log2(LINE_WORDS*4)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
miss_req_i  in  1  cache requests refill; sampled only in IDLE
miss_addr_i  in  32  miss byte address
cached_i  in  1  1 = line burst, 0 = single-word uncached read
busy_o  out  1  engine not in IDLE
done_o  out  1  one-cycle pulse: line_o valid
err_o  out  1  with done_o: beat count differed from expected
line_o  out  LINE_WORDS*32  refilled line, word i = bits [32i+31:32i]; uncached data in word 0
cache_ena_o  out  1  to merger cache_ena input; registered copy of cached_i
ren_o  out  1  to merger ren input; owns the R channel
araddr_o  out  32  to merger araddr input
arvalid_o  out  1  to merger arvalid input
arready_i  in  1  from merger arready
rdata_i  in  32  from merger rdata
rlast_i  in  1  from merger rlast
rvalid_i  in  1  from merger rvalid (R always accepted; merger ties rready high)

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset values: state IDLE; busy_o, done_o, err_o, ren_o, arvalid_o, cache_ena_o = 0; araddr_o = 0; line_o = 0; beat counter = 0.
- FSM states: IDLE, AR, R, DONE.
- IDLE:
  - If miss_req_i = 1, latch the request and go to AR the next cycle.
  - araddr_o = cached_i ? {miss_addr_i[31:OFFSET_W], zeros} : miss_addr_i.
  - cache_ena_o = cached_i.
  - Beat counter = 0.
- AR:
  - arvalid_o = 1 and ren_o = 1.
  - Hold araddr_o and cache_ena_o stable until arready_i = 1 (AXI rule: no deassert before handshake).
  - On arready_i = 1, go to R next cycle; arvalid_o drops in the same edge.
- R:
  - ren_o = 1, arvalid_o = 0.
  - Each cycle with rvalid_i = 1: write rdata_i into line word[counter], then counter++.
  - Counter is log2(LINE_WORDS) bits, wrap-around. Beats beyond LINE_WORDS are discarded (no write) but still counted for the error check.
  - rvalid_i with rlast_i = 1: write the final beat, go to DONE.
  - err = (beats received, including the last one) != expected, where expected = cached ? LINE_WORDS : 1.
  - rvalid_i = 0 cycles: no change. There is no timeout.
- DONE:
  - done_o = 1 and err_o = err for exactly one cycle; ren_o = 0.
  - Return to IDLE next cycle.
  - miss_req_i in DONE is ignored; the cache must re-assert it in IDLE. Minimum request-to-request spacing is therefore 1 idle cycle.
- busy_o = (state != IDLE), combinational from the state register.
- line_o holds its value after DONE until the next R-phase write. Words not written in a short burst keep their stale values, flagged by err_o.
- Latency, cached miss with arready and rvalid every cycle: req(T0) -> AR(T1) -> beats T2..T(1+LINE_WORDS) -> done_o at T(2+LINE_WORDS).
- rst mid-operation: state returns to IDLE and arvalid_o and ren_o drop the next edge. Beats still in flight from the slave are gated off by the merger because ren_o = 0; the block does not drain them.
- Two instances share the merger: the instance owner guarantees only one has ren_o = 1 at a time. This block does no arbitration itself.

Decomposition:
- Shared package/header holds:
  - FSM state encodings (2 bits).
  - Default line geometry constants, consistent with the existing cache burst-length defines.
  - Line-width helper: LINE_WORDS*32.
- One natural sub-module: refill_line_buffer. It contains the word-indexed write-enable register file, the beat counter and the count-mismatch detector. The FSM stays in the top module.

Test Plan:
- Cached miss at 0x1FC0_0024, LINE_WORDS = 8, arready and rvalid every cycle, rdata = 0xA0..0xA7, rlast on beat 8 -> araddr_o = 0x1FC0_0020, cache_ena_o = 1, done_o at T10, line_o words 0..7 = 0xA0..0xA7, err_o = 0.
- Uncached read 0xBFAF_F004 -> araddr_o = 0xBFAF_F004, cache_ena_o = 0, one beat 0xDEAD_BEEF with rlast -> line_o word 0 = 0xDEAD_BEEF, done_o 3 cycles after req, err_o = 0.
- arready held low 5 cycles -> arvalid_o, ren_o and araddr_o stable all 5 cycles; then handshake and normal completion.
- rvalid gaps: beats on alternating cycles -> correct word order, done_o one cycle after the 8th beat.
- Early rlast on beat 4 of a cached burst -> done_o with err_o = 1, words 0..3 updated; 10-beat burst -> err_o = 1, words 0..7 hold the first 8 beats.
- rst asserted during beat 3 -> next cycle busy_o = 0, ren_o = 0; a new miss is accepted and completes cleanly.
